seg_disp_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment display driver between three value sources: source 0 speed, source 1 distance, source 2 alert code.
- Sources 0 and 1 are rotated round-robin at a fixed dwell time.
- Source 2 preempts the rotation and is held for a guaranteed minimum time.
- Output num feeds the display driver's 32-bit num input directly and is always clamped to 0..9999.

---
 rtl/seg_disp_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Shares one 4-digit seven-segment driver between speed, distance and alert sources.
// Sources 0/1 rotate round-robin; source 2 preempts and is held for a minimum time.
module seg_disp_arbiter #(
  parameter int unsigned ROTATE_CYC = 100_000_000,
  parameter int unsigned MIN_HOLD   = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [13:0] val0,
  input  logic [13:0] val1,
  input  logic [13:0] val2,
  output logic [31:0] num,
  output logic [2:0]  grant,
  output logic [1:0]  src_id
);

  localparam int RW = (ROTATE_CYC > 1) ? $clog2(ROTATE_CYC) : 1;
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  localparam logic [RW-1:0] ROT_LAST  = RW'(ROTATE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
  localparam logic [13:0]   NUM_MAX   = 14'd9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_ALERT
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [RW-1:0] rot_cnt_q, rot_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rr_last_q, rr_last_d;
  logic          saved_ptr_q, saved_ptr_d;

  logic [31:0]   num_q, num_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    src_id_q, src_id_d;

  logic          rr_next;
  logic          other;
  logic          saved_other;
  logic [13:0]   val_sel;

  assign rr_next     = ~rr_last_q;
  assign other       = ~ptr_q;
  assign saved_other = ~saved_ptr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rot_cnt_d   = rot_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rr_last_d   = rr_last_q;
    saved_ptr_d = saved_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        rot_cnt_d = '0;
        if (req[2]) begin
          state_d     = S_ALERT;
          hold_cnt_d  = '0;
          saved_ptr_d = rr_next;
        end else if (req[0] | req[1]) begin
          state_d = S_SHOW;
          ptr_d   = req[rr_next] ? rr_next : rr_last_q;
        end
      end

      S_SHOW: begin
        rot_cnt_d = rot_cnt_q + 1'b1;
        if (req[2]) begin
          // Alert wins over drop and expiry; pointer is parked, not advanced.
          state_d     = S_ALERT;
          hold_cnt_d  = '0;
          saved_ptr_d = ptr_q;
          rot_cnt_d   = '0;
        end else if (!req[ptr_q]) begin
          rot_cnt_d = '0;
          if (req[other]) begin
            ptr_d = other;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rot_cnt_q == ROT_LAST) begin
          rot_cnt_d = '0;
          rr_last_d = ptr_q;
          if (req[other]) begin
            ptr_d = other;
          end
        end
      end

      S_ALERT: begin
        rot_cnt_d = '0;
        if (hold_cnt_q == HOLD_LAST && !req[2]) begin
          hold_cnt_d = '0;
          if (req[saved_ptr_q]) begin
            state_d = S_SHOW;
            ptr_d   = saved_ptr_q;
          end else if (req[saved_other]) begin
            state_d = S_SHOW;
            ptr_d   = saved_other;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        rot_cnt_d  = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Outputs follow the next state so a grant appears one cycle after the request.
  always_comb begin
    grant_d  = 3'b000;
    src_id_d = 2'd3;
    val_sel  = '0;
    unique case (1'b1)
      (state_d == S_ALERT): begin
        grant_d  = 3'b100;
        src_id_d = 2'd2;
        val_sel  = val2;
      end
      (state_d == S_SHOW && !ptr_d): begin
        grant_d  = 3'b001;
        src_id_d = 2'd0;
        val_sel  = val0;
      end
      (state_d == S_SHOW && ptr_d): begin
        grant_d  = 3'b010;
        src_id_d = 2'd1;
        val_sel  = val1;
      end
      default: begin
        grant_d  = 3'b000;
        src_id_d = 2'd3;
        val_sel  = '0;
      end
    endcase
    num_d = {18'd0, (val_sel > NUM_MAX) ? NUM_MAX : val_sel};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      rot_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rr_last_q   <= 1'b1;
      saved_ptr_q <= 1'b0;
      num_q       <= '0;
      grant_q     <= 3'b000;
      src_id_q    <= 2'd3;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rot_cnt_q   <= rot_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_last_q   <= rr_last_d;
      saved_ptr_q <= saved_ptr_d;
      num_q       <= num_d;
      grant_q     <= grant_d;
      src_id_q    <= src_id_d;
    end
  end

  assign num    = num_q;
  assign grant  = grant_q;
  assign src_id = src_id_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: directed scenarios plus random traffic,
// all checked against an owner/age reference model.
module tb_seg_disp_arbiter;

  localparam int ROT  = 8;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [13:0] val0, val1, val2;
  logic [31:0] num;
  logic [2:0]  grant;
  logic [1:0]  src_id;

  always #5 clk = ~clk;

  seg_disp_arbiter #(
    .ROTATE_CYC(ROT),
    .MIN_HOLD  (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .val0  (val0),
    .val1  (val1),
    .val2  (val2),
    .num   (num),
    .grant (grant),
    .src_id(src_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // owner: -1 none, 0/1 rotating source, 2 alert
  int m_owner  = -1;
  int m_dwell  = 0;
  int m_age    = 0;
  int m_resume = 0;
  int m_last   = 1;
  int m_num    = 0;
  int m_grant  = 0;
  int m_src    = 3;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int v[3];
    int p, o;
    v[0] = int'(val0);
    v[1] = int'(val1);
    v[2] = int'(val2);
    if (!rst_n) begin
      m_owner = -1; m_dwell = 0; m_age = 0; m_last = 1; m_resume = 0;
    end else if (m_owner == -1) begin
      if (req[2]) begin
        m_owner = 2; m_age = 0; m_resume = 1 - m_last;
      end else if (req[0] || req[1]) begin
        m_owner = req[1 - m_last] ? 1 - m_last : m_last;
        m_dwell = 0;
      end
    end else if (m_owner == 2) begin
      if (m_age >= HOLD - 1 && !req[2]) begin
        o = 1 - m_resume;
        m_owner = req[m_resume] ? m_resume : (req[o] ? o : -1);
        m_dwell = 0;
      end else if (m_age < HOLD - 1) begin
        m_age++;
      end
    end else begin
      p = m_owner;
      o = 1 - p;
      if (req[2]) begin
        m_resume = p; m_owner = 2; m_age = 0; m_dwell = 0;
      end else if (!req[p]) begin
        m_owner = req[o] ? o : -1;
        m_dwell = 0;
      end else if (m_dwell == ROT - 1) begin
        m_last  = p;
        m_owner = req[o] ? o : p;
        m_dwell = 0;
      end else begin
        m_dwell++;
      end
    end
    if (m_owner < 0) begin
      m_num = 0; m_grant = 0; m_src = 3;
    end else begin
      m_num   = (v[m_owner] > 9999) ? 9999 : v[m_owner];
      m_grant = 1 << m_owner;
      m_src   = m_owner;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("grant", 32'(grant), m_grant);
    check_eq("src_id", 32'(src_id), m_src);
    check_eq("num", num, m_num);
  endtask

  task automatic wait_owner(input int o, input int d, input string tag);
    for (int i = 0; i < 64; i++) begin
      if (m_owner == o && (d < 0 || m_dwell == d)) break;
      cyc();
    end
    check_eq(tag, 32'(grant), 1 << o);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    val0  = '0;
    val1  = '0;
    val2  = '0;
    repeat (3) cyc();
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_src", 32'(src_id), 3);
    check_eq("rst_num", num, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_eq("idle_grant", 32'(grant), 0);
    end

    // round-robin dwell
    req  = 3'b011;
    val0 = 14'd123;
    val1 = 14'd4567;
    cyc();
    check_eq("rr_first", 32'(grant), 1);
    check_eq("rr_first_num", num, 123);
    n = 1;
    cyc();
    while (grant == 3'b001 && n < 30) begin n++; cyc(); end
    check_eq("dwell0_len", n, ROT);
    check_eq("rr_second", 32'(grant), 2);
    check_eq("rr_second_num", num, 4567);
    wait_owner(0, -1, "back_to_0");
    val0 = 14'd200;
    cyc();
    check_eq("live_track", num, 200);

    // clamp and single-source re-grant
    req  = 3'b001;
    val0 = 14'd12000;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_eq("clamp_grant", 32'(grant), 1);
      check_eq("clamp_num", num, 9999);
    end
    val0 = 14'd9999;  cyc(); check_eq("edge_9999", num, 9999);
    val0 = 14'd10000; cyc(); check_eq("edge_10000", num, 9999);
    val0 = 14'd16383; cyc(); check_eq("edge_16383", num, 9999);
    val0 = 14'd0;     cyc(); check_eq("edge_0", num, 0);

    // one-cycle alert pulse on source 1 at rot_cnt=3
    req = 3'b011;
    wait_owner(1, 3, "reach_s1_r3");
    req  = 3'b111;
    val2 = 14'd42;
    cyc();
    check_eq("pulse_grant", 32'(grant), 4);
    check_eq("pulse_num", num, 42);
    req = 3'b011;
    n = 1;
    cyc();
    while (grant == 3'b100 && n < 30) begin n++; cyc(); end
    check_eq("pulse_len", n, HOLD);
    check_eq("resume_s1", 32'(grant), 2);
    n = 1;
    cyc();
    while (grant == 3'b010 && n < 30) begin n++; cyc(); end
    check_eq("resume_dwell", n, ROT);

    // alert collides with rotation expiry on source 0
    wait_owner(0, 7, "reach_s0_r7");
    req = 3'b111;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("held_alert", 32'(grant), 4);
    end
    req = 3'b011;
    cyc();
    check_eq("resume_s0", 32'(grant), 1);

    // drop current requester, then everything
    wait_owner(0, -1, "reach_s0");
    req = 3'b010;
    cyc();
    check_eq("drop_to_1", 32'(grant), 2);
    req = 3'b000;
    cyc();
    check_eq("drop_idle", 32'(grant), 0);
    check_eq("drop_idle_num", num, 0);

    // reset mid-show
    req = 3'b011;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    check_eq("mid_rst_grant", 32'(grant), 0);
    check_eq("mid_rst_src", 32'(src_id), 3);
    check_eq("mid_rst_num", num, 0);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        req[1:0] = 2'($urandom_range(0, 3));
        req[2]   = ($urandom_range(0, 7) == 0);
      end else if (req[2] && $urandom_range(0, 2) == 0) begin
        req[2] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) val0 = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) val1 = 14'($urandom_range(9990, 10010));
      if ($urandom_range(0, 3) == 0) val2 = 14'($urandom_range(0, 16383));
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
